// File: rtl/slb_pkg.sv
// Shared types and default parameters for the sliding-line-buffer window controller.
package slb_pkg;

  localparam int SLB_CNT_W  = 5;
  localparam int SLB_K      = 2;
  localparam int SLB_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } slb_state_t;

endpackage

// File: rtl/slb_wrap_counter.sv
// Up-counter with enable and clear that wraps to zero at a runtime limit.
// The wrap flag marks an enabled count that sits on the limit.
module slb_wrap_counter
  import slb_pkg::*;
#(
  parameter int CNT_W = SLB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_limit;

  assign at_limit = (count_q == limit);
  assign wrap     = en & at_limit;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (at_limit) begin
        count_d = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/slb_window_counter.sv
// Frame-aware position and window controller for the maxpooling sliding line buffer.
// Tracks column/row of accepted pixels and flags stride-aligned KxK window completion.
module slb_window_counter
  import slb_pkg::*;
#(
  parameter int CNT_W  = SLB_CNT_W,
  parameter int K      = SLB_K,
  parameter int STRIDE = SLB_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] img_w,
  input  logic [CNT_W-1:0] img_h,
  input  logic             pix_valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             win_valid,
  output logic             line_end,
  output logic             frame_done,
  output logic             busy
);

  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int FILL_LAST_ROW = (K >= 2) ? (K - 2) : 0;
  localparam logic [CNT_W-1:0] K_C   = CNT_W'(K);
  localparam logic [CNT_W-1:0] KM1_C = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] KM2_C = CNT_W'(FILL_LAST_ROW);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STRIDE - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);

  slb_state_t       state_q, state_d;
  logic [CNT_W-1:0] img_w_q, img_w_d;
  logic [CNT_W-1:0] img_h_q, img_h_d;
  logic [PH_W-1:0]  col_ph_q, col_ph_d;
  logic [PH_W-1:0]  row_ph_q, row_ph_d;
  logic             frame_done_q, frame_done_d;

  logic             start_acc;
  logic             size_bad;
  logic             busy_s;
  logic             acc;
  logic [CNT_W-1:0] col_s, row_s;
  logic             col_wrap, row_wrap;
  logic             last_pix;

  assign start_acc = start & (state_q == IDLE);
  assign size_bad  = (img_w < K_C) | (img_h < K_C);
  assign busy_s    = (state_q == FILL) | (state_q == RUN);
  assign acc       = pix_valid & busy_s;
  assign last_pix  = col_wrap & row_wrap;

  slb_wrap_counter #(.CNT_W(CNT_W)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (acc),
    .clr   (start_acc),
    .limit (img_w_q - ONE_C),
    .count (col_s),
    .wrap  (col_wrap)
  );

  slb_wrap_counter #(.CNT_W(CNT_W)) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (col_wrap),
    .clr   (start_acc),
    .limit (img_h_q - ONE_C),
    .count (row_s),
    .wrap  (row_wrap)
  );

  // Phases hold at 0 until their counter reaches K-1, then count modulo STRIDE.
  always_comb begin
    img_w_d  = img_w_q;
    img_h_d  = img_h_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (start_acc) begin
      img_w_d  = img_w;
      img_h_d  = img_h;
      col_ph_d = '0;
      row_ph_d = '0;
    end else if (acc) begin
      if (col_wrap || (col_s < KM1_C)) begin
        col_ph_d = '0;
      end else if (col_ph_q == PH_LAST) begin
        col_ph_d = '0;
      end else begin
        col_ph_d = col_ph_q + PH_ONE;
      end
      if (!col_wrap) begin
        row_ph_d = row_ph_q;
      end else if (row_wrap || (row_s < KM1_C)) begin
        row_ph_d = '0;
      end else if (row_ph_q == PH_LAST) begin
        row_ph_d = '0;
      end else begin
        row_ph_d = row_ph_q + PH_ONE;
      end
    end else begin
      col_ph_d = col_ph_q;
      row_ph_d = row_ph_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!start_acc) begin
          state_d = IDLE;
        end else if (size_bad) begin
          state_d = DONE;
        end else if (K == 1) begin
          state_d = RUN;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (col_wrap && (row_s == KM2_C)) begin
          state_d = RUN;
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        if (last_pix) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      img_w_q      <= '0;
      img_h_q      <= '0;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      img_w_q      <= img_w_d;
      img_h_q      <= img_h_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    busy       = busy_s;
    line_end   = col_wrap;
    frame_done = frame_done_q;
    col        = col_s;
    row        = row_s;
    if ((state_q == RUN) && (row_s >= KM1_C) && (col_s >= KM1_C) &&
        (col_ph_q == '0) && (row_ph_q == '0)) begin
      win_valid = acc;
    end else begin
      win_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_slb_window_counter.sv
// Scoreboard bench: two controllers (K=2/S=2 and K=3/S=1) share stimulus and are
// checked every cycle against a frame-level arithmetic reference model.
module tb_slb_window_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pix_valid;
  logic [4:0] img_w, img_h;
  logic [4:0] col_a, row_a, col_b, row_b;
  logic       win_a, le_a, fd_a, busy_a;
  logic       win_b, le_b, fd_b, busy_b;

  slb_window_counter #(.CNT_W(5), .K(2), .STRIDE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .pix_valid(pix_valid), .col(col_a), .row(row_a), .win_valid(win_a),
    .line_end(le_a), .frame_done(fd_a), .busy(busy_a)
  );

  slb_window_counter #(.CNT_W(5), .K(3), .STRIDE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .pix_valid(pix_valid), .col(col_b), .row(row_b), .win_valid(win_b),
    .line_end(le_b), .frame_done(fd_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [4:0] col;
    logic [4:0] row;
    logic       win;
    logic       le;
    logic       fd;
    logic       busy;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  int passed = 0;
  int total  = 0;
  int kp[2] = '{2, 3};
  int sp[2] = '{2, 1};
  int ms[2];   // 0 idle, 1 in frame, 2 frame_done cycle
  int mn[2];   // pixels accepted so far in the frame
  int mw[2];
  int mh[2];
  int nwin[2];
  int nle[2];

  function automatic obs_t obs_a();
    return obs_t'({col_a, row_a, win_a, le_a, fd_a, busy_a});
  endfunction

  function automatic obs_t obs_b();
    return obs_t'({col_b, row_b, win_b, le_b, fd_b, busy_b});
  endfunction

  function automatic obs_t model_out(int d);
    obs_t e;
    int c, r;
    e = '0;
    if (ms[d] == 1) begin
      c = mn[d] % mw[d];
      r = mn[d] / mw[d];
      e.col  = 5'(c);
      e.row  = 5'(r);
      e.busy = 1'b1;
      if (pix_valid) begin
        e.le  = (c == mw[d] - 1);
        e.win = (r >= kp[d] - 1) && (c >= kp[d] - 1) &&
                ((c - kp[d] + 1) % sp[d] == 0) && ((r - kp[d] + 1) % sp[d] == 0);
      end
    end
    e.fd = (ms[d] == 2);
    return e;
  endfunction

  task automatic model_step(input int d);
    case (ms[d])
      0: if (start) begin
        mw[d] = int'(img_w);
        mh[d] = int'(img_h);
        mn[d] = 0;
        ms[d] = (mw[d] < kp[d] || mh[d] < kp[d]) ? 2 : 1;
      end
      1: if (pix_valid) begin
        mn[d] = mn[d] + 1;
        if (mn[d] == mw[d] * mh[d]) ms[d] = 2;
      end
      default: ms[d] = 0;
    endcase
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got col=%0d row=%0d win=%0b le=%0b fd=%0b busy=%0b, expected col=%0d row=%0d win=%0b le=%0b fd=%0b busy=%0b",
               name, got.col, got.row, got.win, got.le, got.fd, got.busy,
               exp.col, exp.row, exp.win, exp.le, exp.fd, exp.busy);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per DUT per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (qa.size() > 0) compare("dut_a cycle", obs_a(), qa.pop_front());
    if (qb.size() > 0) compare("dut_b cycle", obs_b(), qb.pop_front());
    if (win_a) nwin[0]++;
    if (win_b) nwin[1]++;
    if (le_a)  nle[0]++;
    if (le_b)  nle[1]++;
  end

  task automatic cyc(input bit s, input int w, input int h, input bit pv);
    @(posedge clk);
    #1;
    start = s; img_w = 5'(w); img_h = 5'(h); pix_valid = pv;
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic clr_cnt();
    nwin = '{0, 0};
    nle  = '{0, 0};
  endtask

  task automatic chk_cnt(input string tag, input int wa, input int wb, input int la, input int lb);
    check_int({tag, " win count a"}, nwin[0], wa);
    check_int({tag, " win count b"}, nwin[1], wb);
    check_int({tag, " line_end count a"}, nle[0], la);
    check_int({tag, " line_end count b"}, nle[1], lb);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    start = 1'b0; pix_valid = 1'b0; rst = 1'b1;
    ms = '{0, 0}; mn = '{0, 0};
    #1;
    compare("dut_a async reset", obs_a(), obs_t'(0));
    compare("dut_b async reset", obs_b(), obs_t'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; img_w = 5'd0; img_h = 5'd0;
    ms = '{0, 0}; mn = '{0, 0}; mw = '{1, 1}; mh = '{1, 1};
    clr_cnt();
    #1 rst = 1'b1;
    #1;
    compare("dut_a reset state", obs_a(), obs_t'(0));
    compare("dut_b reset state", obs_b(), obs_t'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // 4x4 with pixels back to back
    clr_cnt();
    cyc(1'b1, 4, 4, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 0, 1'b1);
    idle(2);
    chk_cnt("4x4 dense", 4, 4, 4, 4);

    // 5x4 frame
    clr_cnt();
    cyc(1'b1, 5, 4, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 0, 0, 1'b1);
    idle(2);
    chk_cnt("5x4 dense", 4, 6, 4, 4);

    // 4x4 with pix_valid toggling
    clr_cnt();
    cyc(1'b1, 4, 4, 1'b0);
    for (int i = 0; i < 32; i++) cyc(1'b0, 0, 0, 1'(i % 2 == 0));
    idle(2);
    chk_cnt("4x4 toggle", 4, 4, 4, 4);

    // Undersized frame is rejected
    clr_cnt();
    cyc(1'b1, 1, 4, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1);
    idle(1);
    chk_cnt("reject", 0, 0, 0, 0);

    // Reset after 7 pixels, then a clean frame
    cyc(1'b1, 4, 4, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 0, 0, 1'b1);
    do_reset();
    clr_cnt();
    cyc(1'b1, 4, 4, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 0, 1'b1);
    idle(2);
    chk_cnt("after reset", 4, 4, 4, 4);

    // Start during the frame is ignored
    cyc(1'b1, 4, 4, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b1, 8, 4, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 0, 0, 1'b1);
    idle(2);

    // Randomised traffic, including back-to-back and undersized starts
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    check_int("scoreboard drained a", qa.size(), 0);
    check_int("scoreboard drained b", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
